// File: rtl/ram_bank_clr.sv
// ram_bank_clr -- word-organised single-port RAM with a sequential clear engine.
//
// Depth is 2**addrSize words of 8*wordSizeInByte bits. Writes are byte-masked.
// Reads go through a read register and are flagged by a one-cycle data_valid
// pulse. After reset, or on clear_rq, the array is zeroed one word per cycle.
// Requests are ignored while that runs; ready goes high once the last word
// has been cleared.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   clear_rq   restart the clear engine (zero the whole array)
//   output_en  1: data_out shows read data; 0: data_out forced to 0
//   addr       word address
//   data_in    write data
//   byte_en    per-byte write enable (bit i -> data bits [8i+7:8i])
//   write_rq   write request
//   read_rq    read request
//   ready      1 when requests are accepted (not clearing)
//   data_out   read data
//   data_valid one-cycle pulse: data_out updated by an accepted read
//
// Optional build macro RAM_OUT_REG_EN: adds an output pipeline register after
// the read register. Read latency becomes 2 cycles. Back-to-back reads are
// still accepted one per cycle.
module ram_bank_clr #(
  parameter int addrSize       = 9,
  parameter int wordSizeInByte = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_rq,
  input  logic                        output_en,
  input  logic [addrSize-1:0]         addr,
  input  logic [8*wordSizeInByte-1:0] data_in,
  input  logic [wordSizeInByte-1:0]   byte_en,
  input  logic                        write_rq,
  input  logic                        read_rq,
  output logic                        ready,
  output logic [8*wordSizeInByte-1:0] data_out,
  output logic                        data_valid
);

  localparam int DW    = 8*wordSizeInByte;
  localparam int DEPTH = 1 << addrSize;
  localparam logic [addrSize-1:0] CNT_LAST = '1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              r_state;
  logic [addrSize-1:0] r_cnt;
  logic                r_ready;
  logic [DW-1:0]       r_mem [DEPTH];
  logic [DW-1:0]       r_rd;

  logic          w_acc, w_wr, w_rd;
  logic [DW-1:0] w_old, w_merged, w_rd_word, w_q;

  // clear_rq takes priority over any request in the same cycle.
  assign w_acc = (r_state == S_RUN) && !clear_rq;
  assign w_wr  = w_acc && write_rq;
  assign w_rd  = w_acc && read_rq;

  assign w_old = r_mem[addr];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < wordSizeInByte; i++)
      if (byte_en[i]) w_merged[8*i +: 8] = data_in[8*i +: 8];
  end

  // Write-first: a same-cycle read sees the merged word.
  assign w_rd_word = w_wr ? w_merged : w_old;

  // Control FSM. The counter stops at the terminal word, so it cannot wrap
  // and start the clear again.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (clear_rq) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      if (r_cnt == CNT_LAST) begin
        r_state <= S_RUN;
        r_ready <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // The array itself has no reset. The reset cycle leaves it untouched.
  // A clear_rq cycle does not write, because the counter restarts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (r_state == S_CLEAR && !clear_rq)
        r_mem[r_cnt] <= '0;
      else if (w_wr)
        r_mem[addr] <= w_merged;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [1:0]    r_vld_pipe;
  logic [DW-1:0] r_out;

  always_ff @(posedge clk) begin
    if (!reset || clear_rq || r_state == S_CLEAR) begin
      r_rd       <= '0;
      r_out      <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_rd) r_rd <= w_rd_word;
      if (r_vld_pipe[0]) r_out <= r_rd;
      r_vld_pipe <= {r_vld_pipe[0], w_rd};
    end
  end

  assign w_q        = r_out;
  assign data_valid = r_vld_pipe[1];
`else
  logic [0:0] r_vld_pipe;

  always_ff @(posedge clk) begin
    if (!reset || clear_rq || r_state == S_CLEAR) begin
      r_rd       <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_rd) r_rd <= w_rd_word;
      r_vld_pipe <= w_rd;
    end
  end

  assign w_q        = r_rd;
  assign data_valid = r_vld_pipe[0];
`endif

  assign ready    = r_ready;
  assign data_out = output_en ? w_q : '0;

endmodule

// File: tb/tb_ram_bank_clr.sv
// Self-checking bench for ram_bank_clr (addrSize=4, wordSizeInByte=2).
// The reference model tracks the array as a plain word array. It tracks the
// clear as a count of remaining busy cycles, zeroing the whole array when the
// count reaches zero. It tracks the read path as pending values with a valid
// flag. Directed scenarios are followed by randomized traffic.
module tb_ram_bank_clr;
  localparam int AW = 4, NB = 2, DW = 16, DEPTH = 16;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, clear_rq = 1'b0, output_en = 1'b1;
  logic write_rq = 1'b0, read_rq = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [NB-1:0] byte_en = '0;
  logic ready, data_valid;
  logic [DW-1:0] data_out;

  ram_bank_clr #(.addrSize(AW), .wordSizeInByte(NB)) dut (
    .clk(clk), .reset(reset), .clear_rq(clear_rq), .output_en(output_en),
    .addr(addr), .data_in(data_in), .byte_en(byte_en),
    .write_rq(write_rq), .read_rq(read_rq),
    .ready(ready), .data_out(data_out), .data_valid(data_valid));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference model
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = DEPTH;
  logic [DW-1:0] m_rd = '0, m_out = '0;
  logic          m_v1 = 1'b0, m_v2 = 1'b0;

  task automatic model_edge();
    if (!reset || clear_rq) begin
      m_left = DEPTH;
      m_rd = '0; m_out = '0; m_v1 = 1'b0; m_v2 = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0)
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_rd = '0; m_out = '0; m_v1 = 1'b0; m_v2 = 1'b0;
    end else begin
      if (m_v1) m_out = m_rd;
      m_v2 = m_v1;
      if (write_rq)
        for (int b = 0; b < NB; b++)
          if (byte_en[b]) m_mem[addr][8*b +: 8] = data_in[8*b +: 8];
      if (read_rq) m_rd = m_mem[addr];
      m_v1 = read_rq;
    end
  endtask

  task automatic tick();
    logic [DW-1:0] q;
    logic          v;
    @(posedge clk);
    model_edge();
    #1;
`ifdef RAM_OUT_REG_EN
    q = m_out; v = m_v2;
`else
    q = m_rd;  v = m_v1;
`endif
    chk("ready", {31'b0, ready}, {31'b0, m_left == 0});
    chk("data_valid", {31'b0, data_valid}, {31'b0, v});
    chk("data_out", {16'b0, data_out}, {16'b0, output_en ? q : 16'h0});
  endtask

  task automatic idle();
    write_rq = 1'b0; read_rq = 1'b0; clear_rq = 1'b0; byte_en = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    addr = a; data_in = d; byte_en = be; write_rq = 1'b1;
    tick();
    idle();
  endtask

  // Issue a read and advance to the cycle its data_valid is due.
  task automatic rd(input logic [AW-1:0] a);
    addr = a; read_rq = 1'b1;
    tick();
    idle();
    repeat (LAT-1) tick();
  endtask

  task automatic wait_clear(input string tag);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk({tag, "_busy"}, {31'b0, ready}, 32'd0);
    end
    tick();
    chk({tag, "_done"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    reset = 1'b0;
    tick(); tick();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    reset = 1'b1;
    wait_clear("init");

    for (int a = 0; a < DEPTH; a++) begin
      rd(a[AW-1:0]);
      chk("init_rd", {16'b0, data_out}, 32'h0);
      chk("init_vld", {31'b0, data_valid}, 32'd1);
    end

    wr(4'd3, 16'hBEEF, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    rd(4'd3);
    chk("merge", {16'b0, data_out}, 32'hBE34);
    chk("merge_vld", {31'b0, data_valid}, 32'd1);
    tick();
    chk("vld_pulse", {31'b0, data_valid}, 32'd0);

    addr = 4'd5; data_in = 16'hA5A5; byte_en = 2'b11; write_rq = 1'b1; read_rq = 1'b1;
    tick();
    idle();
    repeat (LAT-1) tick();
    chk("wr_first", {16'b0, data_out}, 32'hA5A5);

    wr(4'd7, 16'h5555, 2'b11);
    clear_rq = 1'b1; write_rq = 1'b1; addr = 4'd8; data_in = 16'hFFFF; byte_en = 2'b11;
    tick();
    idle();
    chk("clr_ready", {31'b0, ready}, 32'd0);
    wait_clear("clrrq");
    rd(4'd7);
    chk("clr_a7", {16'b0, data_out}, 32'h0);
    rd(4'd8);
    chk("clr_a8", {16'b0, data_out}, 32'h0);

    wr(4'd3, 16'hBEEF, 2'b11);
    output_en = 1'b0;
    rd(4'd3);
    chk("oe0_dout", {16'b0, data_out}, 32'h0);
    chk("oe0_vld", {31'b0, data_valid}, 32'd1);
    output_en = 1'b1;
    tick();
    chk("oe1_dout", {16'b0, data_out}, 32'hBEEF);

    clear_rq = 1'b1;
    tick();
    idle();
    repeat (9) tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_clr", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    wait_clear("rerun1");

    addr = 4'd3; read_rq = 1'b1;
    tick();
    idle();
    reset = 1'b0;
    tick();
    chk("rst_rd_vld", {31'b0, data_valid}, 32'd0);
    chk("rst_rd_rdy", {31'b0, ready}, 32'd0);
    reset = 1'b1;
    wait_clear("rerun2");

    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 299) != 0);
      clear_rq  = ($urandom_range(0, 59) == 0);
      write_rq  = $urandom_range(0, 1) == 1;
      read_rq   = $urandom_range(0, 1) == 1;
      addr      = AW'($urandom_range(0, DEPTH-1));
      data_in   = DW'($urandom);
      byte_en   = NB'($urandom_range(0, 3));
      output_en = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_bank_clr.md
Name: ram_bank_clr

Overview:
- Word-organised, parametrised single-port RAM. Successor to the byte-wide RAM block.
- Generalised in word width (N bytes) and depth, with per-byte write enables and an explicit read handshake.
- Replaces the single-cycle whole-array clear with a sequential clear engine: one word per cycle, with a ready flag.
- Sits between the Reflet core memory arbiter and the data bus.

Parameters:
addrSize, 9, word address width; depth = 2**addrSize words
wordSizeInByte, 2, bytes per word; data width = 8*wordSizeInByte

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
clear_rq  input  1  pulse: restart clear engine (zero whole array)
output_en  input  1  1: data_out shows read register; 0: data_out driven 0
addr  input  addrSize  word address
data_in  input  8*wordSizeInByte  write data
byte_en  input  wordSizeInByte  per-byte write enable, bit i -> data bits [8i+7:8i]
write_rq  input  1  write request
read_rq  input  1  read request
ready  output  1  1 when accepting requests (not clearing)
data_out  output  8*wordSizeInByte  read data
data_valid  output  1  1-cycle pulse: data_out updated by accepted read

Behaviour:
- Reset (reset==0 at posedge):
  - state=CLEAR, clear counter=0, ready=0, data_valid=0, internal read register=0.
  - Array contents are not touched in the reset cycle.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle writes all-zero word at counter, then counter+1.
  - When counter==2**addrSize-1 is written, next state=RUN.
  - ready=1 from the following cycle.
  - Clear takes exactly 2**addrSize cycles after reset release.
  - write_rq/read_rq ignored; data_valid=0; read register holds 0.
- RUN:
  - Request accepted when ready==1 at posedge.
  - Write: for each i with byte_en[i]=1, byte i of mem[addr] <= data_in byte i; other bytes unchanged. byte_en==0 -> no change.
  - Read: read register <= mem[addr] on the accepting edge; data_valid=1 the following cycle for one cycle. Latency 1.
  - Read register holds its value until the next accepted read.
  - Simultaneous write_rq and read_rq, same addr: write-first. Read returns merged new word (enabled bytes new, others old).
  - clear_rq=1 in RUN: next state=CLEAR, counter=0, ready=0 next cycle.
    - Any write_rq in the same cycle is dropped.
    - A read_rq in the same cycle is dropped; data_valid stays 0.
  - clear_rq during CLEAR: counter restarts at 0.
- Arithmetic/bounds:
  - addr always in range (full power-of-two depth); no wrap logic needed.
  - Clear counter is addrSize+1 bits or uses an explicit terminal compare; must not wrap back to 0 and loop.
- output_en: purely combinational mask on data_out. Does not affect data_valid or the read register.
- Reset mid-clear or mid-read: reset wins. data_valid forced 0 next cycle; clear restarts from 0.

Optional Feature:
RAM_OUT_REG_EN
- Defined: extra output pipeline register after the read register.
  - Read latency 2: data_valid asserted 2 cycles after acceptance.
  - Pipeline register reset to 0.
  - Pipeline contents discarded (valid cleared) on clear_rq.
  - Back-to-back reads are supported one per cycle.
- Undefined: latency 1 as above; no extra register.

Test Plan:
- Release reset with addrSize=4, wordSizeInByte=2 -> ready=0 for 16 cycles, ready=1 on cycle 17; read every address -> 0x0000, each with data_valid one cycle after request.
- Write addr 3 data 0xBEEF byte_en=11; then write addr 3 data 0x1234 byte_en=01; read addr 3 -> 0xBE34, data_valid exactly 1 cycle wide.
- Same-cycle write addr 5 0xA5A5 byte_en=11 with read addr 5 (prior 0) -> data_out 0xA5A5 next cycle (write-first).
- Write addr 7 0x5555, pulse clear_rq with write_rq addr 8 0xFFFF -> ready low 16 cycles; afterwards addr 7 and addr 8 read 0x0000.
- Read addr 3 (0xBEEF) with output_en=0 -> data_out 0, data_valid 1; raise output_en with no new read -> data_out 0xBEEF.
- Assert reset mid-clear at counter 9 and again during a pending read -> data_valid 0, ready 0, full 16-cycle clear rerun. With RAM_OUT_REG_EN, reads show 2-cycle latency.
